// File: rtl/rv32i_inst_encoder.sv
// rv32i_inst_encoder
//   Packs decoded RV32I fields (opcode, funct3, funct7[5], rd, rs1, rs2,
//   immediate) into a 32-bit machine word and buffers the results in a
//   DEPTH-entry FIFO. Words leave over a valid/ready handshake in strict order.
//
//   Optional build macro: RV32I_ENC_CHECK_EN
//     When defined, each accepted bundle is range-checked. Invalid bundles
//     (bad immediate range/alignment, unsupported opcode) are consumed but
//     dropped, and err is set sticky until reset.
//     When undefined, immediates are truncated, unknown opcodes become NOP,
//     and err stays 0.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           field bundle handshake
//   in_opcode..in_imm           decoded instruction fields
//   out_valid/out_ready         encoded word handshake
//   out_inst                    head word (0 while out_valid=0)
//   level                       FIFO occupancy
//   enc_count                   words popped (wraps at 16 bits)
//   err                         sticky encode error
module rv32i_inst_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               in_opcode,
  input  logic [2:0]               in_funct3,
  input  logic                     in_alt,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              enc_count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [6:0] {
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_BR    = 7'b1100011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_IMM   = 7'b0010011,
    OP_REG   = 7'b0110011
  } opcode_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;
  logic [15:0]   enc_count_q, enc_count_d;
  logic          err_q, err_d;

  logic [31:0]   enc_word;
  logic          is_shift;
  logic          chk_bad;
  logic          accept, push, pop;

  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  // Field packing per instruction format
  always_comb begin
    enc_word = NOP;
    case (in_opcode)
      OP_LUI, OP_AUIPC:
        enc_word = {in_imm[31:12], in_rd, in_opcode};
      OP_JAL:
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      OP_JALR:
        enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, in_opcode};
      OP_BR:
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
      OP_LOAD:
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      OP_STORE:
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      OP_IMM:
        if (is_shift)
          enc_word = {1'b0, in_alt, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
        else
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      OP_REG:
        enc_word = {1'b0, in_alt, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      default:
        enc_word = NOP;
    endcase
  end

`ifdef RV32I_ENC_CHECK_EN
  // Immediate must equal the sign extension of its format's field width
  always_comb begin
    chk_bad = 1'b0;
    case (in_opcode)
      OP_LUI, OP_AUIPC:
        chk_bad = |in_imm[11:0];
      OP_JAL:
        chk_bad = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
      OP_BR:
        chk_bad = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
      OP_JALR, OP_LOAD, OP_STORE:
        chk_bad = (in_imm[31:11] != {21{in_imm[11]}});
      OP_IMM:
        if (is_shift)
          chk_bad = |in_imm[31:5];
        else
          chk_bad = (in_imm[31:11] != {21{in_imm[11]}});
      OP_REG:
        chk_bad = 1'b0;
      default:
        chk_bad = 1'b1;
    endcase
  end
`else
  assign chk_bad = 1'b0;
`endif

  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign out_inst  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign enc_count = enc_count_q;
  assign err       = err_q;

  assign accept = in_valid && in_ready;
  assign push   = accept && !chk_bad;
  assign pop    = out_valid && out_ready;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    enc_count_d = enc_count_q;
    err_d       = err_q | (accept & chk_bad);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      enc_count_d = enc_count_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      enc_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      enc_count_q <= enc_count_d;
      err_q       <= err_d;
    end
  end

  // Storage needs no reset: entries are only read while level_q != 0
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_word;
  end

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
module tb_rv32i_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_alt = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [2:0]  level;
  logic [15:0] enc_count;
  logic        err;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [31:0] sb [$];

  rv32i_inst_encoder #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_alt    (in_alt),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .level     (level),
    .enc_count (enc_count),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
  endtask

  // Output side of the scoreboard: the word shown during a pop cycle
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", 32'(out_valid), 32'd0);
      else chk("out_inst", out_inst, sb.pop_front());
    end
  end

  function automatic logic [31:0] addi_word(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [31:0] imm);
    return {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic alt,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    in_opcode = op; in_funct3 = f3; in_alt = alt;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept(input logic [31:0] exp, input bit keep);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (keep) sb.push_back(exp);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [6:0] op, input logic [2:0] f3, input logic alt,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] exp, input bit keep);
    drive(op, f3, alt, rd, rs1, rs2, imm);
    wait_accept(exp, keep);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((level != 0 || sb.size() != 0) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_sb_left", sb.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst",  out_inst, 32'd0);
    chk("rst_level",     32'(level), 32'd0);
    chk("rst_enc_count", 32'(enc_count), 32'd0);
    chk("rst_err",       32'(err), 32'd0);
    chk("rst_in_ready",  32'(in_ready), 32'd1);

    // ADDI x1, x2, -1 with one-cycle latency
    out_ready = 1'b1;
    push(7'b0010011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b1);
    chk("addi_latency", 32'(out_valid), 32'd1);
    drain();
    chk("addi_enc_count", 32'(enc_count), 32'd1);

    // Format coverage
    push(7'b0110011, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0,         32'h4020_81B3, 1'b1); // SUB
    push(7'b1100011, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b1); // BEQ
    push(7'b1101111, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h8,         32'h0080_00EF, 1'b1); // JAL
    push(7'b0010011, 3'b101, 1'b1, 5'd6, 5'd5, 5'd0, 32'h3,         32'h4032_D313, 1'b1); // SRAI
    push(7'b0110111, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b1); // LUI
    push(7'b0100011, 3'b010, 1'b0, 5'd0, 5'd2, 5'd3, 32'h8,         32'h0031_2423, 1'b1); // SW
    push(7'b1100111, 3'b000, 1'b0, 5'd0, 5'd1, 5'd0, 32'h0,         32'h0000_8067, 1'b1); // JALR
    drain();

    // Backpressure: four fill the FIFO, the fifth stalls
    out_ready = 1'b0;
    for (int unsigned k = 0; k < 4; k++)
      push(7'b0010011, 3'b000, 1'b0, 5'd7, 5'd0, 5'd0, 32'(k + 1),
           addi_word(5'd7, 5'd0, 32'(k + 1)), 1'b1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_level", 32'(level), 32'd4);
    drive(7'b0010011, 3'b000, 1'b0, 5'd7, 5'd0, 5'd0, 32'd5);
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    chk("stall_level", 32'(level), 32'd4);
    out_ready = 1'b1;
    wait_accept(addi_word(5'd7, 5'd0, 32'd5), 1'b1);
    drain();

    // Simultaneous push and pop at level 2
    out_ready = 1'b0;
    push(7'b0010011, 3'b000, 1'b0, 5'd8, 5'd0, 5'd0, 32'd10, addi_word(5'd8, 5'd0, 32'd10), 1'b1);
    push(7'b0010011, 3'b000, 1'b0, 5'd8, 5'd0, 5'd0, 32'd11, addi_word(5'd8, 5'd0, 32'd11), 1'b1);
    chk("pp_level_before", 32'(level), 32'd2);
    drive(7'b0010011, 3'b000, 1'b0, 5'd8, 5'd0, 5'd0, 32'd12);
    out_ready = 1'b1;
    @(posedge clk);
    sb.push_back(addi_word(5'd8, 5'd0, 32'd12));
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("pp_level_after", 32'(level), 32'd2);
    drain();

    // Out-of-range immediate and unsupported opcode
`ifdef RV32I_ENC_CHECK_EN
    out_ready = 1'b0;
    push(7'b0010011, 3'b000, 1'b0, 5'd9, 5'd0, 5'd0, 32'd1, addi_word(5'd9, 5'd0, 32'd1), 1'b1);
    push(7'b0010011, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h800, 32'h0, 1'b0);
    chk("chk_err", 32'(err), 32'd1);
    chk("chk_level", 32'(level), 32'd1);
    push(7'b1111111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    chk("chk_badop_level", 32'(level), 32'd1);
    drain();
    chk("chk_err_sticky", 32'(err), 32'd1);
`else
    push(7'b0010011, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h800, 32'h8000_0013, 1'b1);
    push(7'b1111111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,   32'h0000_0013, 1'b1);
    drain();
    chk("nochk_err", 32'(err), 32'd0);
`endif

    // enc_count wraps after 0x10001 pops
    do_reset();
    chk("wrap_start_count", 32'(enc_count), 32'd0);
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 32'h10001; i++)
      push(7'b0010011, 3'b000, 1'b0, 5'(i), 5'(i >> 5), 5'd0, i & 32'h7FF,
           addi_word(5'(i), 5'(i >> 5), i & 32'h7FF), 1'b1);
    drain();
    chk("wrap_enc_count", 32'(enc_count), 32'd1);

    // Reset mid-operation discards buffered words immediately
    out_ready = 1'b0;
    for (int unsigned k = 0; k < 3; k++)
      push(7'b0010011, 3'b000, 1'b0, 5'd4, 5'd0, 5'd0, 32'(k), addi_word(5'd4, 5'd0, 32'(k)), 1'b1);
    chk("midrst_level_before", 32'(level), 32'd3);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_out_inst", out_inst, 32'd0);
    chk("midrst_enc_count", 32'(enc_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
